// File: rtl/id_ex_pipe_pkg.sv
//----------------------------------------------------------------------------
// Module : id_ex_pipe_pkg
// Shared CPU defines: default widths, NOP encodings, per-edge action decode.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

package id_ex_pipe_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ALUSEL_W = 3;
    localparam int DEF_ALUOP_W  = 8;
    localparam int DEF_RADDR_W  = 5;
    localparam int DEF_STALL_W  = 6;

    localparam logic [DEF_ALUOP_W-1:0]  ALUOP_NOP  = 8'h00;
    localparam logic [DEF_ALUSEL_W-1:0] ALUSEL_NOP = 3'b000;

    typedef enum logic [1:0] {
        ACT_HOLD    = 2'd0,
        ACT_CAPTURE = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } pipe_act_e;

    // Flush beats bubble beats capture beats hold.
    function automatic pipe_act_e decode_act(input logic flush,
                                             input logic stall_here,
                                             input logic stall_next);
        if (flush)
            return ACT_FLUSH;
        if (!stall_here)
            return ACT_CAPTURE;
        if (!stall_next)
            return ACT_BUBBLE;
        return ACT_HOLD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_sat_cnt32.sv
//----------------------------------------------------------------------------
// Module : sat_cnt32
// 32-bit saturating event counter with synchronous clear (clear wins).
// Present only when ID_EX_PIPE_PERF_EN is defined.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

`ifdef ID_EX_PIPE_PERF_EN
module sat_cnt32 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != 32'hFFFF_FFFF))
            count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule
`endif

`default_nettype wire

// File: rtl/id_ex_pipe.sv
//----------------------------------------------------------------------------
// Module : id_ex_pipe
// ID->EX pipeline register with flush/bubble/capture/hold control.
// Optional perf counters enabled by macro ID_EX_PIPE_PERF_EN.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module id_ex_pipe
    import id_ex_pipe_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ALUSEL_W  = DEF_ALUSEL_W,
    parameter int ALUOP_W   = DEF_ALUOP_W,
    parameter int RADDR_W   = DEF_RADDR_W,
    parameter int STALL_W   = DEF_STALL_W,
    parameter int STAGE_IDX = 2
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,

    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [DATA_W-1:0]   id_reg1_data,
    input  logic [DATA_W-1:0]   id_reg2_data,
    input  logic                id_we,
    input  logic [RADDR_W-1:0]  id_waddr,
    input  logic                id_is_in_delayslot,
    input  logic [DATA_W-1:0]   id_link_address,
    input  logic [DATA_W-1:0]   id_inst_addr,
    input  logic                next_inst_in_delayslot_i,

    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [DATA_W-1:0]   ex_reg1_data,
    output logic [DATA_W-1:0]   ex_reg2_data,
    output logic                ex_we,
    output logic [RADDR_W-1:0]  ex_waddr,
    output logic                ex_is_in_delayslot,
    output logic [DATA_W-1:0]   ex_link_address,
    output logic [DATA_W-1:0]   ex_inst_addr,
    output logic                is_in_delayslot_o,
    output logic                ex_valid
`ifdef ID_EX_PIPE_PERF_EN
    ,
    input  logic                perf_clr,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_bubble_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    pipe_act_e act;

    logic [ALUSEL_W-1:0] alusel_q,       alusel_d;
    logic [ALUOP_W-1:0]  aluop_q,        aluop_d;
    logic [DATA_W-1:0]   reg1_data_q,    reg1_data_d;
    logic [DATA_W-1:0]   reg2_data_q,    reg2_data_d;
    logic                we_q,           we_d;
    logic [RADDR_W-1:0]  waddr_q,        waddr_d;
    logic                ex_ds_q,        ex_ds_d;
    logic [DATA_W-1:0]   link_address_q, link_address_d;
    logic [DATA_W-1:0]   inst_addr_q,    inst_addr_d;
    logic                ds_q,           ds_d;
    logic                valid_q,        valid_d;

    // Only this stage's bit and the downstream bit matter.
    logic stall_unused;
    assign stall_unused = ^stall;

    assign act = decode_act(flush, stall[STAGE_IDX], stall[STAGE_IDX+1]);

    always_comb begin
        alusel_d       = alusel_q;
        aluop_d        = aluop_q;
        reg1_data_d    = reg1_data_q;
        reg2_data_d    = reg2_data_q;
        we_d           = we_q;
        waddr_d        = waddr_q;
        ex_ds_d        = ex_ds_q;
        link_address_d = link_address_q;
        inst_addr_d    = inst_addr_q;
        ds_d           = ds_q;
        valid_d        = valid_q;
        case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                alusel_d       = ALUSEL_W'(ALUSEL_NOP);
                aluop_d        = ALUOP_W'(ALUOP_NOP);
                reg1_data_d    = '0;
                reg2_data_d    = '0;
                we_d           = 1'b0;
                waddr_d        = '0;
                ex_ds_d        = 1'b0;
                link_address_d = '0;
                inst_addr_d    = '0;
                valid_d        = 1'b0;
                // A bubble keeps the delay-slot marker for the instruction still in ID.
                if (act == ACT_FLUSH)
                    ds_d = 1'b0;
            end
            ACT_CAPTURE: begin
                alusel_d       = id_alusel;
                aluop_d        = id_aluop;
                reg1_data_d    = id_reg1_data;
                reg2_data_d    = id_reg2_data;
                we_d           = id_we;
                waddr_d        = id_waddr;
                ex_ds_d        = id_is_in_delayslot;
                link_address_d = id_link_address;
                inst_addr_d    = id_inst_addr;
                ds_d           = next_inst_in_delayslot_i;
                valid_d        = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alusel_q       <= '0;
            aluop_q        <= '0;
            reg1_data_q    <= '0;
            reg2_data_q    <= '0;
            we_q           <= 1'b0;
            waddr_q        <= '0;
            ex_ds_q        <= 1'b0;
            link_address_q <= '0;
            inst_addr_q    <= '0;
            ds_q           <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            alusel_q       <= alusel_d;
            aluop_q        <= aluop_d;
            reg1_data_q    <= reg1_data_d;
            reg2_data_q    <= reg2_data_d;
            we_q           <= we_d;
            waddr_q        <= waddr_d;
            ex_ds_q        <= ex_ds_d;
            link_address_q <= link_address_d;
            inst_addr_q    <= inst_addr_d;
            ds_q           <= ds_d;
            valid_q        <= valid_d;
        end
    end

    assign ex_alusel          = alusel_q;
    assign ex_aluop           = aluop_q;
    assign ex_reg1_data       = reg1_data_q;
    assign ex_reg2_data       = reg2_data_q;
    assign ex_we              = we_q;
    assign ex_waddr           = waddr_q;
    assign ex_is_in_delayslot = ex_ds_q;
    assign ex_link_address    = link_address_q;
    assign ex_inst_addr       = inst_addr_q;
    assign is_in_delayslot_o  = ds_q;
    assign ex_valid           = valid_q;

`ifdef ID_EX_PIPE_PERF_EN
    sat_cnt32 u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (act == ACT_HOLD),
        .clr     (perf_clr),
        .count   (perf_stall_cnt)
    );

    sat_cnt32 u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (act == ACT_BUBBLE),
        .clr     (perf_clr),
        .count   (perf_bubble_cnt)
    );

    sat_cnt32 u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (act == ACT_FLUSH),
        .clr     (perf_clr),
        .count   (perf_flush_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameters (name, default, meaning): DATA_W, 32, operand/link/PC width; ALUSEL_W, 3, ALU select width; ALUOP_W, 8, ALU opcode width; RADDR_W, 5, register address width; STALL_W, 6, stall vector width; STAGE_IDX, 2, this stage's bit in the stall vector (0 < STAGE_IDX < STALL_W-1).
REQ-002 SHALL have ports (name, direction, width, meaning): clk, in, 1, single clock; reset_n, in, 1, asynchronous active-low reset.
REQ-003 SHALL have: stall, in, STALL_W, per-stage stall request; flush, in, 1, pipeline flush.
REQ-004 SHALL have ID-side inputs: id_alusel ALUSEL_W; id_aluop ALUOP_W; id_reg1_data and id_reg2_data DATA_W; id_we 1; id_waddr RADDR_W; id_is_in_delayslot 1; id_link_address DATA_W; id_inst_addr DATA_W; next_inst_in_delayslot_i 1.
REQ-005 SHALL have EX-side outputs mirroring REQ-004 with prefix ex_, plus is_in_delayslot_o (1) and ex_valid (1, a real instruction is held).
REQ-006 SHALL, with ID_EX_PIPE_PERF_EN defined, add outputs perf_stall_cnt, perf_bubble_cnt and perf_flush_cnt (32 each), plus input perf_clr (1).

Function
REQ-007 SHALL update all outputs on the rising edge of clk only; there is no combinational path from inputs to outputs.
REQ-008 SHALL apply per-edge priority: flush > bubble > capture > hold.
REQ-009 Flush: all ex_* outputs, ex_valid and is_in_delayslot_o SHALL become 0 on the next edge.
REQ-010 Bubble (stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0): all ex_* outputs and ex_valid SHALL become 0 (NOP, ex_we=0); is_in_delayslot_o SHALL hold.
REQ-011 Capture (stall[STAGE_IDX]=0): every ex_* output SHALL load its id_* input; ex_valid SHALL become 1; is_in_delayslot_o SHALL load next_inst_in_delayslot_i.
REQ-012 Hold (stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1): all outputs SHALL keep their values.
REQ-013 Latency SHALL be exactly one cycle from ID inputs to EX outputs during capture.
REQ-014 Stall bits other than STAGE_IDX and STAGE_IDX+1 SHALL be ignored.
REQ-015 Perf counters (when compiled in): perf_stall_cnt SHALL increment in each hold cycle; perf_bubble_cnt in each bubble cycle; perf_flush_cnt in each flush cycle. Each SHALL saturate at 0xFFFFFFFF.
REQ-016 perf_clr SHALL zero all counters on the next edge, with priority over increment in that cycle.

Reset
REQ-017 While reset_n=0, all outputs including counters SHALL be 0 asynchronously, independent of clk.
REQ-018 Reset deasserted mid-stall SHALL leave outputs at 0 until the first flush, bubble or capture edge; hold keeps the zeros.

Configuration
REQ-019 Macro ID_EX_PIPE_PERF_EN: when defined, the counters, perf_clr and the perf_* ports SHALL exist. When undefined, those ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-020 The shared CPU defines file SHALL hold ALUOP_NOP and ALUSEL_NOP (both 0) and the default widths; the bubble and flush values SHALL use these constants.
REQ-021 The perf counter SHALL be one sub-module, sat_cnt32 (inc, clr, count), instantiated three times under the macro.

Verification
REQ-022 Reset: reset_n=0 at mid-cycle -> all outputs 0 before the next clk edge; release, then capture id_reg1_data=0x12345678 -> ex_reg1_data=0x12345678 and ex_valid=1 one cycle later.
REQ-023 Bubble: stall=6'b000111 with id_we=1 and id_waddr=5 -> ex_we=0, ex_waddr=0, ex_aluop=0, ex_valid=0; is_in_delayslot_o unchanged.
REQ-024 Hold: stall=6'b001111 for 3 cycles after capturing aluop=0x21 -> ex_aluop stays 0x21 and perf_stall_cnt=3.
REQ-025 Flush wins: flush=1 with stall=0 and valid ID inputs -> all outputs 0, perf_flush_cnt increments by 1.
REQ-026 Delay slot: capture with next_inst_in_delayslot_i=1 and id_link_address=0x00400008 -> is_in_delayslot_o=1 and ex_link_address=0x00400008; then bubble -> is_in_delayslot_o stays 1.
REQ-027 Saturation: counter forced to 0xFFFFFFFE, two hold cycles -> 0xFFFFFFFF; perf_clr together with a hold -> 0.
